// File: rtl/sync_fifo_queue_pkg.sv
// Shared constants and helpers for the sync_fifo_queue FWFT FIFO.
// Imported by the storage sub-module and the top-level controller.
package sync_fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DEF = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 32;

    // Per-cycle queue operation, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Advance a pointer by one, wrapping at depth-1 so depth need not be a power of two.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_queue_if.sv
// Producer/consumer bundle for sync_fifo_queue: push side, FWFT pop side and flags.
// The master drives the queue; the slave is the queue itself.
interface sync_fifo_queue_if #(
    parameter int unsigned WIDTH = sync_fifo_pkg::FIFO_WIDTH_DEF
) ();

    logic [WIDTH-1:0] wdata;
    logic             we;
    logic             re;
    logic [WIDTH-1:0] rdata;
    logic             full;
    logic             empty;

    modport master (
        output wdata, we, re,
        input  rdata, full, empty
    );

    modport slave (
        input  wdata, we, re,
        output rdata, full, empty
    );

endinterface

// File: rtl/sync_fifo_queue_mem.sv
// fifo_mem: DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port. Holds data only; all queue bookkeeping is in the top.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; empty_o masks stale words, and leaving it out lets the array map to plain flops or RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_queue.sv
// sync_fifo_queue: single-clock first-word-fall-through FIFO (UART RX/TX byte queue).
// Optional feature macro SYNC_FIFO_QUEUE_LEVEL_EN adds level_o = current occupancy.
module sync_fifo_queue
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       we_i,
    input  logic                       re_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
`ifdef SYNC_FIFO_QUEUE_LEVEL_EN
    output logic [$clog2(DEPTH+1)-1:0] level_o,
`endif
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push, pop;
    fifo_op_e         op;
    logic [WIDTH-1:0] mem_rdata;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside a read.
    assign push = we_i & (~full_o | re_i);
    assign pop  = re_i & ~empty_o;
    assign op   = fifo_op_e'({push, pop});

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end
        if (pop) begin
            rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end
        case (op)
            OP_PUSH: count_d = count_q + CNT_W'(1);
            OP_POP:  count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push & rst_ni),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    assign rdata_o = empty_o ? '0 : mem_rdata;

`ifdef SYNC_FIFO_QUEUE_LEVEL_EN
    assign level_o = count_q;
`endif

endmodule

// File: tb/tb_sync_fifo_queue.sv
// Directed self-checking bench for sync_fifo_queue (WIDTH=8, DEPTH=32).
// Exercises level_o as well when SYNC_FIFO_QUEUE_LEVEL_EN is defined.
module tb_sync_fifo_queue;

    localparam int W = 8;
    localparam int D = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_queue_if #(.WIDTH(W)) fifo_if ();
`ifdef SYNC_FIFO_QUEUE_LEVEL_EN
    logic [5:0] level;
`endif

    sync_fifo_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .wdata_i (fifo_if.wdata),
        .we_i    (fifo_if.we),
        .re_i    (fifo_if.re),
        .rdata_o (fifo_if.rdata),
        .full_o  (fifo_if.full),
`ifdef SYNC_FIFO_QUEUE_LEVEL_EN
        .level_o (level),
`endif
        .empty_o (fifo_if.empty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [W-1:0] d);
        fifo_if.we    = we;
        fifo_if.re    = re;
        fifo_if.wdata = d;
    endtask

    task automatic check_level(input string tag, input int exp);
`ifdef SYNC_FIFO_QUEUE_LEVEL_EN
        check(tag, 32'(level), exp);
`else
        if (exp < 0) $display("unreachable %s", tag);
`endif
    endtask

    initial begin
        logic [W-1:0] model [$];
        int           pushed, popped, cycles;
        logic         we_r, re_r, do_push, do_pop;
        logic [W-1:0] exp_head;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1. Reset state, pop on empty, and simultaneous push/pop on empty.
        check("rst_empty", 32'(fifo_if.empty), 1);
        check("rst_full",  32'(fifo_if.full),  0);
        check("rst_rdata", 32'(fifo_if.rdata), 0);
        check_level("rst_level", 0);
        drive(1'b0, 1'b1, '0);
        tick();
        check("pop_empty_empty", 32'(fifo_if.empty), 1);
        check("pop_empty_rdata", 32'(fifo_if.rdata), 0);
        drive(1'b1, 1'b1, 8'h3C);
        tick();
        check("rw_empty_empty", 32'(fifo_if.empty), 0);
        check("rw_empty_rdata", 32'(fifo_if.rdata), 32'h3C);
        check_level("rw_empty_level", 1);
        drive(1'b0, 1'b1, '0);
        tick();
        check("rw_empty_drain", 32'(fifo_if.empty), 1);

        // 2. Single push then pop.
        drive(1'b1, 1'b0, 8'hA5);
        tick();
        check("push_a5_empty", 32'(fifo_if.empty), 0);
        check("push_a5_rdata", 32'(fifo_if.rdata), 32'hA5);
        drive(1'b0, 1'b1, '0);
        tick();
        check("pop_a5_empty", 32'(fifo_if.empty), 1);
        check("pop_a5_rdata", 32'(fifo_if.rdata), 0);

        // 3. Fill, overflow drop, drain in order.
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 1'b0, W'(i));
            tick();
            if (i == D - 2) check("almost_full", 32'(fifo_if.full), 0);
        end
        check("fill_full", 32'(fifo_if.full), 1);
        check_level("fill_level", D);
        drive(1'b1, 1'b0, 8'hFF);
        tick();
        check("ovf_full",  32'(fifo_if.full),  1);
        check("ovf_rdata", 32'(fifo_if.rdata), 0);
        for (int i = 0; i < D; i++) begin
            drive(1'b0, 1'b1, '0);
            check($sformatf("drain_%0d", i), 32'(fifo_if.rdata), i);
            tick();
        end
        drive(1'b0, 1'b0, '0);
        check("drain_empty", 32'(fifo_if.empty), 1);
        check("drain_rdata", 32'(fifo_if.rdata), 0);

        // 4. Simultaneous push and pop while full.
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 1'b0, W'(i));
            tick();
        end
        drive(1'b1, 1'b1, 8'h55);
        tick();
        check("full_rw_full",  32'(fifo_if.full),  1);
        check("full_rw_rdata", 32'(fifo_if.rdata), 1);
        for (int i = 1; i < D; i++) begin
            drive(1'b0, 1'b1, '0);
            check($sformatf("full_rw_drain_%0d", i), 32'(fifo_if.rdata), i);
            tick();
        end
        check("full_rw_last", 32'(fifo_if.rdata), 32'h55);
        tick();
        drive(1'b0, 1'b0, '0);
        check("full_rw_empty", 32'(fifo_if.empty), 1);

        // 5. Streaming with random gaps against a queue scoreboard.
        pushed = 0;
        popped = 0;
        cycles = 0;
        while ((pushed < 100 || model.size() > 0) && cycles < 5000) begin
            we_r = (pushed < 100) && ($urandom_range(0, 3) != 0);
            re_r = ($urandom_range(0, 2) != 0);
            drive(we_r, re_r, W'(pushed * 7 + 3));
            exp_head = (model.size() > 0) ? model[0] : '0;
            check("stream_rdata", 32'(fifo_if.rdata), 32'(exp_head));
            check("stream_empty", 32'(fifo_if.empty), 32'(model.size() == 0));
            check("stream_full",  32'(fifo_if.full),  32'(model.size() == D));
            do_pop  = re_r && (model.size() > 0);
            do_push = we_r && ((model.size() < D) || re_r);
            tick();
            if (do_pop) begin
                void'(model.pop_front());
                popped++;
            end
            if (do_push) begin
                model.push_back(W'(pushed * 7 + 3));
                pushed++;
            end
            cycles++;
        end
        drive(1'b0, 1'b0, '0);
        check("stream_done",   32'(popped), 100);
        check("stream_empty2", 32'(fifo_if.empty), 1);

        // 6. Reset mid-operation with a concurrent push and pop.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, W'(8'h10 + i));
            tick();
            check_level($sformatf("load_level_%0d", i + 1), i + 1);
        end
        check("load_rdata", 32'(fifo_if.rdata), 32'h10);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 8'hEE);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0);
        check("mid_rst_empty", 32'(fifo_if.empty), 1);
        check("mid_rst_full",  32'(fifo_if.full),  0);
        check("mid_rst_rdata", 32'(fifo_if.rdata), 0);
        check_level("mid_rst_level", 0);
        drive(1'b1, 1'b0, 8'h77);
        tick();
        drive(1'b0, 1'b0, '0);
        check("post_rst_rdata", 32'(fifo_if.rdata), 32'h77);
        check_level("post_rst_level", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
